// File: rtl/system_qsy_nios2_qsys_mulx_pkg.sv
// ---------------------------------------------------------------------------
// system_qsy_nios2_qsys_mulx_pkg
// Shared types and constants for the Nios II MUL/MULX sequencer.
//   op_e      : request opcode (MUL low word, MULX* high word variants)
//   state_e   : sequencer FSM states
//   PP_*      : partial-product indices; bit1 selects the high half of src1,
//               bit0 selects the high half of src2
//   pp_tag_t  : tag carried alongside each cell pass while it is in flight
//   pp_shift  : accumulation shift table for each partial
// Optional feature macro used by the design: MULX_SEQ_SIGNED_EN
// ---------------------------------------------------------------------------
package system_qsy_nios2_qsys_mulx_pkg;

  typedef enum logic [1:0] {
    OP_MUL    = 2'b00,
    OP_MULXUU = 2'b01,
    OP_MULXSU = 2'b10,
    OP_MULXSS = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_DRAIN = 3'd2,
    ST_CORR  = 3'd3,
    ST_RESP  = 3'd4
  } state_e;

  localparam logic [1:0] PP_LL = 2'd0;
  localparam logic [1:0] PP_LH = 2'd1;
  localparam logic [1:0] PP_HL = 2'd2;
  localparam logic [1:0] PP_HH = 2'd3;

  typedef struct packed {
    logic       vld;
    logic       last;
    logic [1:0] idx;
  } pp_tag_t;

  function automatic logic [5:0] pp_shift(input logic [1:0] idx);
    case (idx)
      PP_LL:        pp_shift = 6'd0;
      PP_LH, PP_HL: pp_shift = 6'd16;
      default:      pp_shift = 6'd32;
    endcase
  endfunction

endpackage

// File: rtl/system_qsy_nios2_qsys_mulx_acc.sv
// ---------------------------------------------------------------------------
// system_qsy_nios2_qsys_mulx_acc
// 64-bit shift-add accumulator with a high-word sign-correction subtractor.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   i_clr        : zero the accumulator (new request)
//   i_add        : add i_addend shifted by the table entry for i_pp_idx
//   i_pp_idx     : partial index selecting the shift
//   i_addend     : 32-bit cell result
//   i_corr       : subtract i_sub_a and i_sub_b from the high word (mod 2^32)
//   i_sub_a/b    : correction terms (zero when no correction applies)
//   o_acc        : current 64-bit accumulator value
// Strobes are mutually exclusive by construction in the sequencer; the
// priority below only fixes behaviour if that ever changes.
// ---------------------------------------------------------------------------
module system_qsy_nios2_qsys_mulx_acc
  import system_qsy_nios2_qsys_mulx_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_clr,
  input  logic        i_add,
  input  logic [1:0]  i_pp_idx,
  input  logic [31:0] i_addend,
  input  logic        i_corr,
  input  logic [31:0] i_sub_a,
  input  logic [31:0] i_sub_b,
  output logic [63:0] o_acc
);

  logic [63:0] r_acc;
  logic [63:0] w_term;
  logic [31:0] w_hi_corr;

  assign w_term    = {32'd0, i_addend} << pp_shift(i_pp_idx);
  assign w_hi_corr = r_acc[63:32] - i_sub_a - i_sub_b;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_acc <= '0;
    end else if (i_clr) begin
      r_acc <= '0;
    end else if (i_add) begin
      r_acc <= r_acc + w_term;
    end else if (i_corr) begin
      r_acc <= {w_hi_corr, r_acc[31:0]};
    end
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/system_qsy_nios2_qsys_mulx_seq.sv
// ---------------------------------------------------------------------------
// system_qsy_nios2_qsys_mulx_seq
// Sequencer in front of the external 32-bit Nios II multiply cell.
// MUL runs as one full-width cell pass; MULXUU/MULXSU/MULXSS run as four
// 16x16 passes (LL, LH, HL, HH) accumulated into 64 bits, then a signed
// correction of the high word.
// Ports:
//   clk, reset_n      : clock, asynchronous active-low reset
//   req_valid/ready   : request handshake (ready only in IDLE)
//   req_op            : 00 MUL, 01 MULXUU, 10 MULXSU, 11 MULXSS
//   req_src1/src2     : operands
//   rsp_valid/ready   : response handshake
//   rsp_result        : MUL low word or MULX* high word
//   rsp_illegal       : op not supported in this build
//   mul_src1/src2     : cell operands, zero whenever no pass is issued
//   mul_cell_result   : cell low product, CELL_LATENCY cycles after issue
// Build option: MULX_SEQ_SIGNED_EN enables MULXSU/MULXSS. Without it those
// ops are accepted, skip the cell entirely and answer with rsp_illegal=1.
// ---------------------------------------------------------------------------
module system_qsy_nios2_qsys_mulx_seq
  import system_qsy_nios2_qsys_mulx_pkg::*;
#(
  parameter int CELL_LATENCY = 1
)
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_src1,
  input  logic [31:0] req_src2,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_illegal,
  output logic [31:0] mul_src1,
  output logic [31:0] mul_src2,
  input  logic [31:0] mul_cell_result
);

  state_e      r_state, w_state_next;
  op_e         r_op;
  logic [31:0] r_a, r_b;
  logic [1:0]  r_pp_idx;
  logic        r_illegal;

  logic        w_accept;
  logic        w_req_illegal;
  pp_tag_t     w_issue_tag;
  pp_tag_t     w_res_tag;
  pp_tag_t     r_pipe [CELL_LATENCY];

  logic        w_corr;
  logic [31:0] w_sub_a, w_sub_b;
  logic [63:0] w_acc;

  assign w_accept = (r_state == ST_IDLE) && req_valid;

`ifdef MULX_SEQ_SIGNED_EN
  assign w_req_illegal = 1'b0;
  // Unsigned 64-bit product high word, corrected for two's-complement
  // operands: a negative src1 contributes -src2*2^32, likewise for src2.
  assign w_sub_a = (((r_op == OP_MULXSU) || (r_op == OP_MULXSS)) && r_a[31]) ? r_b : 32'd0;
  assign w_sub_b = ((r_op == OP_MULXSS) && r_b[31]) ? r_a : 32'd0;
  assign w_corr  = (r_state == ST_CORR);
`else
  assign w_req_illegal = req_op[1];
  assign w_sub_a       = 32'd0;
  assign w_sub_b       = 32'd0;
  assign w_corr        = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_op      <= OP_MUL;
      r_a       <= '0;
      r_b       <= '0;
      r_pp_idx  <= PP_LL;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_op      <= op_e'(req_op);
        r_a       <= req_src1;
        r_b       <= req_src2;
        r_pp_idx  <= PP_LL;
        r_illegal <= w_req_illegal;
      end else if (r_state == ST_ISSUE) begin
        r_pp_idx <= r_pp_idx + 2'd1;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_issue_tag  = '0;
    mul_src1     = '0;
    mul_src2     = '0;
    case (r_state)
      ST_IDLE: begin
        if (req_valid) w_state_next = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (r_illegal) begin
          w_state_next = ST_RESP;
        end else if (r_op == OP_MUL) begin
          mul_src1         = r_a;
          mul_src2         = r_b;
          w_issue_tag.vld  = 1'b1;
          w_issue_tag.last = 1'b1;
          w_issue_tag.idx  = PP_LL;
          w_state_next     = ST_DRAIN;
        end else begin
          mul_src1         = {16'd0, r_pp_idx[1] ? r_a[31:16] : r_a[15:0]};
          mul_src2         = {16'd0, r_pp_idx[0] ? r_b[31:16] : r_b[15:0]};
          w_issue_tag.vld  = 1'b1;
          w_issue_tag.last = (r_pp_idx == PP_HH);
          w_issue_tag.idx  = r_pp_idx;
          if (r_pp_idx == PP_HH) w_state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (w_res_tag.vld && w_res_tag.last)
          w_state_next = (r_op == OP_MUL) ? ST_RESP : ST_CORR;
      end
      ST_CORR: begin
        w_state_next = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Tag delay line matching the cell latency: the tail entry marks the cycle
  // in which mul_cell_result belongs to one of our passes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < CELL_LATENCY; i++) r_pipe[i] <= '0;
    end else begin
      r_pipe[0] <= w_issue_tag;
      for (int i = 1; i < CELL_LATENCY; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign w_res_tag = r_pipe[CELL_LATENCY-1];

  system_qsy_nios2_qsys_mulx_acc u_acc (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_clr    (w_accept),
    .i_add    (w_res_tag.vld),
    .i_pp_idx (w_res_tag.idx),
    .i_addend (mul_cell_result),
    .i_corr   (w_corr),
    .i_sub_a  (w_sub_a),
    .i_sub_b  (w_sub_b),
    .o_acc    (w_acc)
  );

  assign req_ready   = (r_state == ST_IDLE);
  assign rsp_valid   = (r_state == ST_RESP);
  assign rsp_illegal = rsp_valid && r_illegal;
  assign rsp_result  = (rsp_valid && !r_illegal)
                     ? ((r_op == OP_MUL) ? w_acc[31:0] : w_acc[63:32])
                     : 32'd0;

endmodule

// File: tb/tb_system_qsy_nios2_qsys_mulx_seq.sv
module tb_system_qsy_nios2_qsys_mulx_seq;

  localparam int L = 1;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = 2'b00;
  logic [31:0] req_src1 = 32'd0;
  logic [31:0] req_src2 = 32'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_result;
  logic        rsp_illegal;
  logic [31:0] mul_src1, mul_src2, mul_cell_result;

  system_qsy_nios2_qsys_mulx_seq #(.CELL_LATENCY(L)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_op          (req_op),
    .req_src1        (req_src1),
    .req_src2        (req_src2),
    .rsp_valid       (rsp_valid),
    .rsp_ready       (rsp_ready),
    .rsp_result      (rsp_result),
    .rsp_illegal     (rsp_illegal),
    .mul_src1        (mul_src1),
    .mul_src2        (mul_src2),
    .mul_cell_result (mul_cell_result)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Multiply cell model: L-deep register of the low 32-bit product.
  logic [31:0] cell_pipe [L];
  always @(posedge clk) begin
    cell_pipe[0] <= mul_src1 * mul_src2;
    for (int i = 1; i < L; i++) cell_pipe[i] <= cell_pipe[i-1];
  end
  assign mul_cell_result = cell_pipe[L-1];

  typedef struct {
    logic [31:0] res;
    logic        ill;
    int          cyc;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  // Monitor: pops an expectation on the first cycle of each response and
  // re-checks result stability while the response is held.
  exp_t cur;
  bit   presented = 1'b0;
  bit   have_cur  = 1'b0;
  always @(negedge clk) begin
    if (!reset_n || !rsp_valid) begin
      presented = 1'b0;
      have_cur  = 1'b0;
    end else if (!presented) begin
      presented = 1'b1;
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("[TB] FAIL unexpected_rsp: got result 0x%08h illegal %0b, expected no response", rsp_result, rsp_illegal);
      end else begin
        cur      = sb.pop_front();
        have_cur = 1'b1;
        check({cur.name, "_result"}, rsp_result, cur.res);
        check({cur.name, "_illegal"}, 32'(rsp_illegal), 32'(cur.ill));
        check({cur.name, "_cycle"}, 32'(cyc), 32'(cur.cyc));
        $display("[TB] %s result=0x%08h illegal=%0b", cur.name, rsp_result, rsp_illegal);
      end
    end else if (have_cur) begin
      check({cur.name, "_stable"}, rsp_result, cur.res);
    end
  end

  // Drive a request; the expectation is pushed at the negedge before the
  // accepting edge, with the response cycle counted from that edge.
  task automatic issue(input string nm, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] res, input logic ill,
                       input int lat);
    exp_t e;
    bit   ok = 1'b0;
    req_op    = op;
    req_src1  = a;
    req_src2  = b;
    req_valid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (req_ready) begin
        e.res  = res;
        e.ill  = ill;
        e.cyc  = cyc + lat;
        e.name = nm;
        sb.push_back(e);
        ok = 1'b1;
      end
    end
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("[TB] FAIL %s_accept: req_ready stayed 0, expected 1 within 50 cycles", nm);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !rsp_valid) ok = 1'b1;
    end
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("[TB] FAIL drain_timeout: %0d responses outstanding, expected 0", sb.size());
      sb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_outputs_reset(input string nm);
    check({nm, "_req_ready"}, 32'(req_ready), 32'd1);
    check({nm, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({nm, "_rsp_result"}, rsp_result, 32'd0);
    check({nm, "_rsp_illegal"}, 32'(rsp_illegal), 32'd0);
    check({nm, "_mul_src1"}, mul_src1, 32'd0);
    check({nm, "_mul_src2"}, mul_src2, 32'd0);
  endtask

  logic [31:0] pp_a [4];
  logic [31:0] pp_b [4];

  initial begin
    bit ok;

    repeat (2) @(posedge clk);
    #1;
    check_outputs_reset("reset");
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    issue("mul_basic", 2'b00, 32'h0001_0003, 32'h0002_0005, 32'h000B_000F, 1'b0, 2 + L);
    wait_idle();

    issue("mulxuu_ones", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 6 + L);
    wait_idle();

    // Distinct halves so the LL, LH, HL, HH order is visible on the cell bus.
    pp_a = '{32'd1, 32'd1, 32'd2, 32'd2};
    pp_b = '{32'd3, 32'd4, 32'd3, 32'd4};
    issue("mulxuu_order", 2'b01, 32'h0002_0001, 32'h0004_0003, 32'h0000_0008, 1'b0, 6 + L);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("pp%0d_src1", k), mul_src1, pp_a[k]);
      check($sformatf("pp%0d_src2", k), mul_src2, pp_b[k]);
    end
    @(negedge clk);
    check("drain_src1_zero", mul_src1, 32'd0);
    wait_idle();

`ifdef MULX_SEQ_SIGNED_EN
    issue("mulxss_neg1x2", 2'b11, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0, 6 + L);
    wait_idle();
    issue("mulxsu_min", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 6 + L);
    wait_idle();
    issue("mulxss_neg1sq", 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 6 + L);
    wait_idle();
`else
    issue("mulxss_illegal", 2'b11, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0000, 1'b1, 2);
    @(negedge clk);
    check("illegal_no_pass_src1", mul_src1, 32'd0);
    check("illegal_no_pass_src2", mul_src2, 32'd0);
    wait_idle();
    issue("mulxsu_illegal", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 2);
    wait_idle();
`endif

    // Consumer stall: result held, no new accept, cell bus idle.
    rsp_ready = 1'b0;
    issue("mul_stall", 2'b00, 32'd7, 32'd6, 32'd42, 1'b0, 2 + L);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (rsp_valid) ok = 1'b1;
    end
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("[TB] FAIL stall_wait: rsp_valid stayed 0, expected 1 within 20 cycles");
    end
    for (int i = 0; i < 5; i++) begin
      check("stall_req_ready", 32'(req_ready), 32'd0);
      check("stall_rsp_valid", 32'(rsp_valid), 32'd1);
      check("stall_mul_src1", mul_src1, 32'd0);
      check("stall_mul_src2", mul_src2, 32'd0);
      @(negedge clk);
    end
    #1;
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("release_req_ready", 32'(req_ready), 32'd1);
    check("release_rsp_valid", 32'(rsp_valid), 32'd0);
    wait_idle();

    // Reset during the third issue cycle aborts the request.
    issue("mulxuu_aborted", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 6 + L);
    repeat (2) @(posedge clk);
    #1;
    check("abort_hl_src1", mul_src1, 32'h0000_FFFF);
    #1;
    reset_n = 1'b0;
    sb.delete();
    #1;
    check_outputs_reset("midop_reset");
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check("post_reset_idle", 32'(rsp_valid), 32'd0);

    issue("mulxuu_after_rst", 2'b01, 32'd3, 32'd5, 32'h0000_0000, 1'b0, 6 + L);
    wait_idle();

    issue("mulxuu_2p32", 2'b01, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 1'b0, 6 + L);
    wait_idle();

    issue("mul_wrap", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 2 + L);
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
